pad_strip_stream: RTL and testbench
===================================

// Module: pad_strip_stream
// PURPOSE
//  Inverse of the ifmap zero-pad stage: streaming crop of a padded feature map.
//  Input is a raster stream of a C x (iH+2P) x (iH+2P) BF16 map, ordered channel, then row, then col.
//  Block drops the P-wide border and forwards only the C x iH x iH interior, in the same order.
//  Sits between the PE-array output and the ofmap buffer, or on the DMA readback path.
// PARAMETERS
//  C   3   channels per frame
//  iH  4   unpadded (interior) height and width
//  P   1   border width; P=0 means pass-through
//  BW  16  element width (bfloat16)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse; arms one frame; ignored unless in IDLE
//  s_data     in   BW  padded input element
//  s_valid    in   1   input element valid
//  s_ready    out  1   block accepts s_data this cycle
//  m_data     out  BW  interior output element
//  m_valid    out  1   output element valid
//  m_ready    in   1   downstream accepts m_data
//  m_last     out  1   with m_valid: last interior element of frame (ch C-1, row iH-1, col iH-1)
//  done       out  1   1-cycle pulse after the final output beat is accepted
//  pad_err    out  1   sticky border-nonzero flag (PAD_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - W = iH+2P. Counters: col and row are $clog2(W) bits wide (min 1); ch is $clog2(C) bits wide (min 1).
//  - FSM states:
//    IDLE:   start moves to STREAM; counters clear.
//    STREAM: input beats are consumed.
//    DRAIN:  entered after the last input beat; waits until the output register is empty.
//    DONE:   one cycle with done=1, then returns to IDLE.
//  - s_ready = (state==STREAM) && (!m_valid || m_ready). An input beat is accepted when s_valid && s_ready.
//  - Counters advance on each accepted beat: col wraps W-1 to 0 and increments row; row wraps W-1 to 0 and increments ch.
//  - Interior beat: P <= row < iH+P and P <= col < iH+P.
//    - On accept, it loads m_data and sets m_valid on the next edge (1-cycle latency).
//    - m_last is registered with the beat.
//  - Border beat: accepted and discarded; m_valid stays unchanged unless m_ready clears it.
//  - Output register: m_valid clears on m_valid && m_ready unless a new interior beat is loaded in the same cycle.
//    - Simultaneous drain and load gives full throughput: 1 beat/cycle with m_ready held high.
//    - m_data and m_last are held stable while m_valid && !m_ready.
//  - Accept of the final padded beat (ch=C-1, row=W-1, col=W-1) moves to DRAIN.
//    - DRAIN moves to DONE when the register is empty, or when it is being drained this cycle.
//  - start while in STREAM, DRAIN or DONE is ignored; no queuing.
//  - P=0: every beat is interior and the block is a 1-deep registered pipe.
//  - Reset (async, any state): state=IDLE; counters=0; m_valid=0; m_data=0; m_last=0; done=0; pad_err=0.
//    - A partially streamed frame is lost; the next frame requires a new start.
//  - s_valid in IDLE is not accepted (s_ready=0). Upstream holds data; no beats are dropped.
// CONFIGURATION
//  - PAD_CHECK_EN defined:
//    - Every accepted border beat with s_data != 0 sets pad_err on the next edge.
//    - pad_err holds until rst_n or until the next start (cleared on start in IDLE).
//    - Both +0 and -0 count as zero: a border beat with s_data == {1'b1,{BW-1{1'b0}}} does not set pad_err.
//  - PAD_CHECK_EN undefined: no check logic; pad_err is constant 0.
// TESTING
//  1. Defaults, start, 108 padded beats with value = index+1, border beats = 0, m_ready=1
//     -> 48 outputs, first = 8 (ch0 r1 c1), last = 101 with m_last; done 1 cycle later; pad_err=0.
//  2. As test 1 but m_ready toggling 1,0,1,0
//     -> same 48 values in order; m_data stable while stalled; s_ready=0 while m_valid && !m_ready.
//  3. P=0, iH=2, C=1, 4 beats back-to-back
//     -> 4 outputs at 1 beat/cycle, 1-cycle latency; m_last on beat 4.
//  4. Assert rst_n low after 40 input beats -> all outputs 0 immediately; state IDLE.
//     Then start plus a full frame -> a correct frame as in test 1.
//  5. PAD_CHECK_EN, border beat ch1 r0 c3 = 16'h3F80 -> pad_err=1 the next cycle and stays set.
//     Border beat 16'h8000 -> pad_err stays 0.
//     Interior output stream is unaffected.
//  6. start pulsed during STREAM and DONE, and s_valid held high in IDLE
//     -> no frame restart; s_ready=0 in IDLE; exactly 48 outputs per start.

Source files
------------

// File: rtl/pad_strip_stream.sv
// ---------------------------------------------------------------------------
// pad_strip_stream
//
// Streaming crop of a zero-padded feature map (the inverse of the ifmap pad
// stage).  The input is a raster stream of a C x W x W map, W = IH + 2*P,
// ordered channel, then row, then column.  The P-wide border is consumed and
// discarded; only the C x IH x IH interior is forwarded, in the same order,
// through a single output register.
//
// Optional feature (compile-time macro PAD_CHECK_EN):
//   When defined, any accepted border element whose value is not +0 or -0
//   sets the sticky pad_err flag.  When undefined, pad_err is tied to 0 and
//   no check logic exists.
//
// Parameters
//   C   channels per frame
//   IH  interior height/width
//   P   border width (0 = plain 1-deep registered pipe)
//   BW  element width
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, arms one frame (only honoured in IDLE)
//   s_data     in   padded input element
//   s_valid    in   input element valid
//   s_ready    out  block accepts s_data this cycle
//   m_data     out  interior output element
//   m_valid    out  output element valid
//   m_ready    in   downstream accepts m_data
//   m_last     out  with m_valid: last interior element of the frame
//   done       out  1-cycle pulse once the frame has fully left the block
//   pad_err    out  sticky non-zero-border flag (0 without PAD_CHECK_EN)
//   dbg_state  out  current FSM state (0 IDLE, 1 STREAM, 2 DRAIN, 3 DONE)
//
// Handshake: both sides use valid/ready.  A beat transfers on a rising edge
// where valid && ready are both high; valid never waits on ready, and once
// m_valid is raised, m_data/m_last hold until the beat is taken.
// ---------------------------------------------------------------------------
module pad_strip_stream #(
  parameter int C  = 3,
  parameter int IH = 4,
  parameter int P  = 1,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [BW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [BW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          done,
  output logic          pad_err,
  output logic [1:0]    dbg_state
);

  localparam int W  = IH + 2 * P;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int HW = (C > 1) ? $clog2(C) : 1;

  localparam logic [CW-1:0] POS_MAX = CW'(W - 1);
  localparam logic [CW-1:0] IN_LAST = CW'(IH + P - 1);
  localparam logic [HW-1:0] CH_MAX  = HW'(C - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col, row;
  logic [HW-1:0] ch;

  logic acc;        // input beat transfers on this edge
  logic interior;   // current position lies inside the border
  logic last_in;    // current position is the final padded element
  logic last_out;   // current position is the final interior element
  logic out_free;   // output register is empty or emptying this cycle

  // -------------------------------------------------------------------------
  // Position decode
  // -------------------------------------------------------------------------
  generate
    if (P == 0) begin : g_no_border
      assign interior = 1'b1;
    end else begin : g_border
      localparam logic [CW-1:0] LO = CW'(P);
      localparam logic [CW-1:0] IN_W = CW'(IH);
      logic [CW-1:0] row_off, col_off;
      // Positions above/left of the border wrap to a large unsigned offset
      // (>= IH, since 2**CW >= IH + 2P), so one compare covers both edges.
      assign row_off  = row - LO;
      assign col_off  = col - LO;
      assign interior = (row_off < IN_W) && (col_off < IN_W);
    end
  endgenerate

  assign last_in  = (ch == CH_MAX) && (row == POS_MAX) && (col == POS_MAX);
  assign last_out = (ch == CH_MAX) && (row == IN_LAST) && (col == IN_LAST);
  assign out_free = !m_valid || m_ready;
  assign acc      = s_valid && s_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if (acc && last_in) state_nxt = S_DRAIN;
      // Leave as soon as the register is empty or is handing off its beat.
      S_DRAIN:  if (out_free) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    s_ready   = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      S_STREAM: s_ready = out_free;
      S_DONE:   done    = 1'b1;
      default: begin
        s_ready = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Raster position counters (col fastest, then row, then channel)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (state == S_IDLE) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (acc) begin
      if (col == POS_MAX) begin
        col <= '0;
        if (row == POS_MAX) begin
          row <= '0;
          ch  <= (ch == CH_MAX) ? '0 : ch + HW'(1);
        end else begin
          row <= row + CW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register.  A load takes priority over a drain, so a beat leaving
  // and a beat arriving on the same edge keeps m_valid high (1 beat/cycle).
  // Border beats are consumed without touching the register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (acc && interior) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_last  <= last_out;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Border value check.  The sign bit is ignored so -0 counts as zero.
  // -------------------------------------------------------------------------
`ifdef PAD_CHECK_EN
  logic pad_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_err_q <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      pad_err_q <= 1'b0;
    end else if (acc && !interior && (s_data[BW-2:0] != '0)) begin
      pad_err_q <= 1'b1;
    end
  end

  assign pad_err = pad_err_q;
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_pad_strip_stream.sv
// ---------------------------------------------------------------------------
// tb_pad_strip_stream
//
// Bench for pad_strip_stream.  Main instance uses the default geometry
// (C=3, IH=4, P=1); a second instance (C=1, IH=2, P=0) exercises the
// pass-through pipe.  Frames are built as plain arrays; the expected output
// is the interior of that array in raster order, kept in exp_q.
// ---------------------------------------------------------------------------
module tb_pad_strip_stream;

  localparam int C    = 3;
  localparam int IH   = 4;
  localparam int P    = 1;
  localparam int BW   = 16;
  localparam int W    = IH + 2 * P;
  localparam int N    = C * W * W;
  localparam int NOUT = C * IH * IH;

`ifdef PAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT ----------------
  logic          start, s_valid, s_ready, m_valid, m_ready, m_last, done, pad_err;
  logic [BW-1:0] s_data, m_data;
  logic [1:0]    dbg_state;

  pad_strip_stream #(.C(C), .IH(IH), .P(P), .BW(BW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .pad_err(pad_err), .dbg_state(dbg_state)
  );

  // ---------------- pass-through DUT ----------------
  logic          z_start, z_svalid, z_sready, z_mvalid, z_mready, z_mlast, z_done, z_pad_err;
  logic [BW-1:0] z_sdata, z_mdata;
  logic [1:0]    z_state;

  pad_strip_stream #(.C(1), .IH(2), .P(0), .BW(BW)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(z_start),
    .s_data(z_sdata), .s_valid(z_svalid), .s_ready(z_sready),
    .m_data(z_mdata), .m_valid(z_mvalid), .m_ready(z_mready), .m_last(z_mlast),
    .done(z_done), .pad_err(z_pad_err), .dbg_state(z_state)
  );

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  logic [BW:0]   exp_q[$];      // {last, data}
  logic [BW-1:0] frame[N];
  logic [BW-1:0] zd[4];
  bit            exp_pad = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_border(input int i);
    int r, c;
    r = (i / W) % W;
    c = i % W;
    return (r < P) || (r >= IH + P) || (c < P) || (c >= IH + P);
  endfunction

  // kind 0: interior = index+1, border 0
  // kind 1: random interior, border +0/-0 with 16'h3F80 at ch1 r0 c3
  // kind 2: random interior, border +0/-0 only
  // kind 3: everything random
  task automatic build_frame(input int kind);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (is_border(i)) begin
        case (kind)
          0:       frame[i] = '0;
          1:       frame[i] = (i == 1 * W * W + 0 * W + 3) ? 16'h3F80
                              : ($urandom_range(0, 1) ? 16'h8000 : 16'h0000);
          2:       frame[i] = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
          default: frame[i] = 16'($urandom);
        endcase
      end else begin
        frame[i] = (kind == 0) ? 16'(i + 1) : 16'($urandom);
        exp_q.push_back({1'b0, frame[i]});
      end
    end
    exp_q[exp_q.size() - 1][BW] = 1'b1;
  endtask

  // ---------------- drivers ----------------
  // vmode: 0 s_valid always, 1 random.  rmode: 0 ready high, 1 toggle, 2 random.
  // abort_at > 0: async reset once that many input beats are accepted.
  task automatic run_frame(input int kind, input int vmode, input int rmode,
                           input int abort_at, input bit extra_start);
    int idx, outs, cyc, last_out_cyc, last_in_cyc;
    bit fin;
    idx = 0; outs = 0; cyc = 0; last_out_cyc = -10; last_in_cyc = -10; fin = 1'b0;
    build_frame(kind);
    while (!fin && cyc < 3000) begin
      @(posedge clk); #1;
      start   = (cyc == 0) || (extra_start && (idx == N || $urandom_range(0, 3) == 0));
      s_valid = (cyc > 0) && (idx < N) && (vmode == 0 || $urandom_range(0, 2) != 0);
      s_data  = s_valid ? frame[idx] : 16'($urandom);
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("pad_err", pad_err, exp_pad);
      if (cyc == 0) exp_pad = 1'b0;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 1, 0);
        end else begin
          check("m_data", m_data, exp_q[0][BW-1:0]);
          check("m_last", m_last, exp_q[0][BW]);
        end
        if (m_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          outs++;
          last_out_cyc = cyc;
        end else begin
          check("s_ready_stall", s_ready, 0);
        end
      end
      if (s_valid && s_ready) begin
        if (CHK && is_border(idx) && frame[idx][BW-2:0] != '0) exp_pad = 1'b1;
        idx++;
        if (idx == N) last_in_cyc = cyc;
      end
      if (done) begin
        fin = 1'b1;
        check("done_cycle", cyc,
              (last_in_cyc + 2 > last_out_cyc + 1) ? last_in_cyc + 2 : last_out_cyc + 1);
      end
      if (abort_at > 0 && idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_done", done, 0);
        check("rst_pad_err", pad_err, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_state", dbg_state, 0);
        exp_pad = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b0; rst_n = 1'b1;
        return;
      end
      cyc++;
    end
    if (!fin) check("timeout", 1, 0);
    check("out_count", outs, NOUT);
    check("in_count", idx, N);
    check("exp_q_empty", exp_q.size(), 0);
    // Idle with s_valid held high: nothing may be taken or produced.
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_s_ready", s_ready, 0);
      check("idle_m_valid", m_valid, 0);
      check("idle_done", done, 0);
      check("idle_state", dbg_state, 0);
      check("idle_pad_err", pad_err, exp_pad);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic zero_test();
    for (int k = 0; k < 4; k++) zd[k] = 16'($urandom);
    @(posedge clk); #1;
    z_start = 1'b1; z_mready = 1'b1;
    @(negedge clk);
    check("z_idle_s_ready", z_sready, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      z_start = 1'b0; z_svalid = 1'b1; z_sdata = zd[k];
      @(negedge clk);
      check("z_s_ready", z_sready, 1);
      if (k > 0) begin
        check("z_m_valid", z_mvalid, 1);
        check("z_m_data", z_mdata, zd[k-1]);
        check("z_m_last", z_mlast, 0);
      end else begin
        check("z_first_m_valid", z_mvalid, 0);
      end
    end
    @(posedge clk); #1;
    z_svalid = 1'b0;
    @(negedge clk);
    check("z_m_valid_4", z_mvalid, 1);
    check("z_m_data_4", z_mdata, zd[3]);
    check("z_m_last_4", z_mlast, 1);
    check("z_done_early", z_done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("z_done", z_done, 1);
    check("z_m_valid_end", z_mvalid, 0);
    check("z_pad_err", z_pad_err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("z_done_pulse", z_done, 0);
    check("z_state_idle", z_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    z_start = 1'b0; z_svalid = 1'b0; z_sdata = '0; z_mready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_last", m_last, 0);
    check("reset_done", done, 0);
    check("reset_pad_err", pad_err, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_state", dbg_state, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(0, 0, 0, 0, 1'b0);   // index+1 frame, full throughput
    run_frame(0, 0, 1, 0, 1'b0);   // m_ready toggling
    zero_test();                   // P=0 pass-through
    run_frame(0, 1, 2, 40, 1'b0);  // abort mid-frame with reset
    run_frame(0, 0, 0, 0, 1'b0);   // clean frame after abort
    run_frame(1, 1, 2, 0, 1'b0);   // non-zero border at ch1 r0 c3
    run_frame(2, 0, 0, 0, 1'b0);   // +0/-0 border only, flag cleared by start
    run_frame(0, 1, 2, 0, 1'b1);   // stray start pulses in STREAM/DRAIN/DONE
    for (int f = 0; f < 4; f++)
      run_frame(3, 1, 2, 0, 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
